// File: rtl/dbg_mem_arbiter.sv
// Round-robin arbiter that shares the InstRAM/DataRAM debug ports between the
// program loader (requester 0) and the readback monitor (requester 1).
module dbg_mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_sel,
  input  logic [3:0]  req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_sel,
  input  logic [3:0]  req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] inst_a2,
  output logic [31:0] inst_wd2,
  output logic [3:0]  inst_we2,
  input  logic [31:0] inst_rd2,
  output logic [31:0] data_a2,
  output logic [31:0] data_wd2,
  output logic [3:0]  data_we2,
  input  logic [31:0] data_rd2,
  output logic        cpu_hold,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_rr, r_owner, r_sel;
  logic [3:0]  r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;

  logic w_idle, w_grant0, w_grant1, w_accept, w_last_wait;

  // Ready is gated by reset so every output reads 0 while rst is low.
  assign w_idle      = rst && (r_state == S_IDLE);
  assign w_grant0    = req0_valid && (!req1_valid || !r_rr);
  assign w_grant1    = req1_valid && (!req0_valid ||  r_rr);
  assign req0_ready  = w_idle && w_grant0;
  assign req1_ready  = w_idle && w_grant1;
  assign w_accept    = req0_ready || req1_ready;
  assign w_last_wait = (r_state == S_WAIT) && (r_cnt == 3'd1);

  always_comb begin
    // NOTE: defaults come first so every path through the case assigns both
    // signals; a missing assignment here would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = LAT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (w_last_wait) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: captured request fields are reset too, so the RAM ports and the
    // response bus read 0 both during reset and right after it.
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_sel   <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_owner <= req1_ready;
        r_rr    <= ~req1_ready;
        r_sel   <= req1_ready ? req1_sel   : req0_sel;
        r_we    <= req1_ready ? req1_we    : req0_we;
        r_addr  <= req1_ready ? req1_addr  : req0_addr;
        r_wdata <= req1_ready ? req1_wdata : req0_wdata;
      end
      // The RAM read data is only trusted on the final WAIT cycle.
      if (w_last_wait)
        r_rdata <= (r_we != 4'd0) ? 32'h0 : (r_sel ? data_rd2 : inst_rd2);
    end
  end

  assign inst_a2    = r_addr;
  assign data_a2    = r_addr;
  assign inst_wd2   = r_wdata;
  assign data_wd2   = r_wdata;
  assign inst_we2   = (r_state == S_ISSUE && !r_sel) ? r_we : 4'd0;
  assign data_we2   = (r_state == S_ISSUE &&  r_sel) ? r_we : 4'd0;
  assign rsp0_valid = (r_state == S_RESP) && !r_owner;
  assign rsp1_valid = (r_state == S_RESP) &&  r_owner;
  assign rsp_rdata  = r_rdata;
  assign busy       = (r_state != S_IDLE);
  assign cpu_hold   = busy && !r_sel && (r_we != 4'd0);

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Bench for dbg_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) checked every
// cycle against a transaction-phase model, plus hand-computed directed checks.
module tb_dbg_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v0 [2], v1 [2], s0 [2], s1 [2];
  logic [3:0]  we0 [2], we1 [2];
  logic [31:0] a0 [2], a1 [2], wd0 [2], wd1 [2], ird [2], drd [2];
  logic        rdy0 [2], rdy1 [2], rv0 [2], rv1 [2], hold [2], bsy [2];
  logic [31:0] rdata [2], ia2 [2], iwd2 [2], da2 [2], dwd2 [2];
  logic [3:0]  iwe2 [2], dwe2 [2];

  dbg_mem_arbiter #(.RD_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_sel(s0[0]), .req0_we(we0[0]),
    .req0_addr(a0[0]), .req0_wdata(wd0[0]), .rsp0_valid(rv0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_sel(s1[0]), .req1_we(we1[0]),
    .req1_addr(a1[0]), .req1_wdata(wd1[0]), .rsp1_valid(rv1[0]),
    .rsp_rdata(rdata[0]),
    .inst_a2(ia2[0]), .inst_wd2(iwd2[0]), .inst_we2(iwe2[0]), .inst_rd2(ird[0]),
    .data_a2(da2[0]), .data_wd2(dwd2[0]), .data_we2(dwe2[0]), .data_rd2(drd[0]),
    .cpu_hold(hold[0]), .busy(bsy[0])
  );

  dbg_mem_arbiter #(.RD_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_sel(s0[1]), .req0_we(we0[1]),
    .req0_addr(a0[1]), .req0_wdata(wd0[1]), .rsp0_valid(rv0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_sel(s1[1]), .req1_we(we1[1]),
    .req1_addr(a1[1]), .req1_wdata(wd1[1]), .rsp1_valid(rv1[1]),
    .rsp_rdata(rdata[1]),
    .inst_a2(ia2[1]), .inst_wd2(iwd2[1]), .inst_we2(iwe2[1]), .inst_rd2(ird[1]),
    .data_a2(da2[1]), .data_wd2(dwd2[1]), .data_we2(dwe2[1]), .data_rd2(drd[1]),
    .cpu_hold(hold[1]), .busy(bsy[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_k is the cycle index since the accept edge (0 = no transaction).
  // Cycle 1 drives the write strobe, cycles 2..lat+1 wait, cycle lat+2 responds.
  int          m_k [2] = '{0, 0};
  logic        m_rr [2] = '{1'b0, 1'b0};
  logic        m_owner [2] = '{1'b0, 1'b0};
  logic        m_sel [2] = '{1'b0, 1'b0};
  logic [3:0]  m_we [2] = '{4'd0, 4'd0};
  logic [31:0] m_addr [2] = '{32'd0, 32'd0};
  logic [31:0] m_wdata [2] = '{32'd0, 32'd0};
  logic [31:0] m_rdata [2] = '{32'd0, 32'd0};

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int winner(input int d);
    if (v0[d] && v1[d]) return m_rr[d] ? 1 : 0;
    if (v0[d]) return 0;
    if (v1[d]) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int w;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_k[d] <= 0; m_rr[d] <= 1'b0; m_owner[d] <= 1'b0; m_sel[d] <= 1'b0;
        m_we[d] <= 4'd0; m_addr[d] <= 32'd0; m_wdata[d] <= 32'd0; m_rdata[d] <= 32'd0;
      end else if (m_k[d] == 0) begin
        w = winner(d);
        if (w >= 0) begin
          m_owner[d] <= (w == 1);
          m_rr[d]    <= (w == 0);
          m_sel[d]   <= (w == 1) ? s1[d]  : s0[d];
          m_we[d]    <= (w == 1) ? we1[d] : we0[d];
          m_addr[d]  <= (w == 1) ? a1[d]  : a0[d];
          m_wdata[d] <= (w == 1) ? wd1[d] : wd0[d];
          m_k[d]     <= 1;
        end
      end else begin
        if (m_k[d] == lat_of(d) + 1)
          m_rdata[d] <= (m_we[d] != 4'd0) ? 32'h0 : (m_sel[d] ? drd[d] : ird[d]);
        m_k[d] <= (m_k[d] == lat_of(d) + 2) ? 0 : m_k[d] + 1;
      end
    end
  end

  task automatic compare(input int d);
    logic e_r0, e_r1, e_rv0, e_rv1, e_hold, e_busy;
    logic [3:0] e_iwe, e_dwe;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int w;
    e_r0 = 1'b0; e_r1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_hold = 1'b0; e_busy = 1'b0;
    e_iwe = 4'd0; e_dwe = 4'd0; e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0;
    if (rst) begin
      w       = (m_k[d] == 0) ? winner(d) : -1;
      e_r0    = (w == 0);
      e_r1    = (w == 1);
      e_busy  = (m_k[d] != 0);
      e_iwe   = (m_k[d] == 1 && !m_sel[d]) ? m_we[d] : 4'd0;
      e_dwe   = (m_k[d] == 1 &&  m_sel[d]) ? m_we[d] : 4'd0;
      e_hold  = e_busy && !m_sel[d] && (m_we[d] != 4'd0);
      e_rv0   = (m_k[d] == lat_of(d) + 2) && !m_owner[d];
      e_rv1   = (m_k[d] == lat_of(d) + 2) &&  m_owner[d];
      e_addr  = m_addr[d];
      e_wdata = m_wdata[d];
      e_rdata = m_rdata[d];
    end
    check($sformatf("d%0d_req0_ready", d), rdy0[d], e_r0);
    check($sformatf("d%0d_req1_ready", d), rdy1[d], e_r1);
    check($sformatf("d%0d_rsp0_valid", d), rv0[d], e_rv0);
    check($sformatf("d%0d_rsp1_valid", d), rv1[d], e_rv1);
    check($sformatf("d%0d_rsp_rdata", d), rdata[d], e_rdata);
    check($sformatf("d%0d_inst_we2", d), iwe2[d], e_iwe);
    check($sformatf("d%0d_data_we2", d), dwe2[d], e_dwe);
    check($sformatf("d%0d_inst_a2", d), ia2[d], e_addr);
    check($sformatf("d%0d_data_a2", d), da2[d], e_addr);
    check($sformatf("d%0d_inst_wd2", d), iwd2[d], e_wdata);
    check($sformatf("d%0d_data_wd2", d), dwd2[d], e_wdata);
    check($sformatf("d%0d_cpu_hold", d), hold[d], e_hold);
    check($sformatf("d%0d_busy", d), bsy[d], e_busy);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) compare(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   q[$];
    int   n0, n1, overlap, rsp_cyc;
    logic [31:0] got;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v0[d] = 0; v1[d] = 0; s0[d] = 0; s1[d] = 0; we0[d] = 0; we1[d] = 0;
      a0[d] = 0; a1[d] = 0; wd0[d] = 0; wd1[d] = 0; ird[d] = 0; drd[d] = 0;
    end
    repeat (3) tick();
    v0[0] = 1;
    #1;
    check("rst_ready_gated", rdy0[0], 1'b0);
    check("rst_busy", bsy[0], 1'b0);
    v0[0] = 0;
    rst = 1'b1;
    tick();

    // Read of DataRAM by requester 0, RD_LAT=1.
    drd[0] = 32'hDEADBEEF;
    s0[0] = 1; we0[0] = 4'd0; a0[0] = 32'h10; v0[0] = 1;
    #2 check("t1_ready_c0", rdy0[0], 1'b1);
    tick();
    v0[0] = 0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      check($sformatf("t1_data_a2_c%0d", c), da2[0], 32'h10);
      check($sformatf("t1_data_we2_c%0d", c), dwe2[0], 4'd0);
      check($sformatf("t1_hold_c%0d", c), hold[0], 1'b0);
      check($sformatf("t1_rsp0_c%0d", c), rv0[0], (c == 3));
      if (c == 3) check("t1_rdata", rdata[0], 32'hDEADBEEF);
      tick();
    end

    // InstRAM write by requester 1.
    s1[0] = 0; we1[0] = 4'hF; a1[0] = 32'h4; wd1[0] = 32'h00500093; v1[0] = 1;
    #2;
    check("t2_ready_c0", rdy1[0], 1'b1);
    check("t2_hold_c0", hold[0], 1'b0);
    tick();
    v1[0] = 0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      check($sformatf("t2_inst_we2_c%0d", c), iwe2[0], (c == 1) ? 4'hF : 4'h0);
      check($sformatf("t2_hold_c%0d", c), hold[0], 1'b1);
      check($sformatf("t2_rsp1_c%0d", c), rv1[0], (c == 3));
      if (c == 1) check("t2_inst_wd2", iwd2[0], 32'h00500093);
      if (c == 1) check("t2_inst_a2", ia2[0], 32'h4);
      if (c == 3) check("t2_rdata", rdata[0], 32'h0);
      tick();
    end
    #2 check("t2_hold_idle", hold[0], 1'b0);
    tick();

    // Both requesters held valid: grants must alternate starting with 0.
    drd[0] = 32'h12345678;
    s0[0] = 1; we0[0] = 0; a0[0] = 32'h100;
    s1[0] = 1; we1[0] = 0; a1[0] = 32'h200;
    v0[0] = 1; v1[0] = 1;
    n0 = 0; n1 = 0; overlap = 0;
    for (int i = 0; i < 16; i++) begin
      #2;
      if (rdy0[0]) q.push_back(0);
      if (rdy1[0]) q.push_back(1);
      if (rv0[0]) n0++;
      if (rv1[0]) n1++;
      if ((rv0[0] || rv1[0]) && (rdy0[0] || rdy1[0])) overlap++;
      tick();
    end
    v0[0] = 0; v1[0] = 0;
    check("t3_grant_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_grant%0d", i), (i < q.size()) ? q[i] : 32'hFFFF_FFFF, i % 2);
    check("t3_rsp0_count", n0, 2);
    check("t3_rsp1_count", n1, 2);
    check("t3_rsp_ready_overlap", overlap, 0);
    tick();

    // RD_LAT=3 read: rd2 must be taken on the last WAIT cycle only.
    drd[1] = 32'h11111111;
    s0[1] = 1; we0[1] = 0; a0[1] = 32'h20; v0[1] = 1;
    #2 check("t4_ready_c0", rdy0[1], 1'b1);
    tick();
    v0[1] = 0;
    rsp_cyc = -1; got = 32'h0; n0 = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) drd[1] = 32'hAAAA0003;
      if (c == 4) drd[1] = 32'h5A5A1234;
      if (c == 5) drd[1] = 32'hBBBB0005;
      #2;
      if (rv0[1]) begin rsp_cyc = c; got = rdata[1]; n0++; end
      tick();
    end
    check("t4_rsp_cycle", rsp_cyc, 5);
    check("t4_rsp_count", n0, 1);
    check("t4_rdata", got, 32'h5A5A1234);

    // Reset in the middle of WAIT of an InstRAM write by requester 0.
    s0[0] = 0; we0[0] = 4'b0011; a0[0] = 32'h8; wd0[0] = 32'hCAFEBABE; v0[0] = 1;
    #2 check("t5_ready_c0", rdy0[0], 1'b1);
    tick();
    v0[0] = 0;
    tick();
    #1;
    check("t5_busy_wait", bsy[0], 1'b1);
    check("t5_hold_wait", hold[0], 1'b1);
    rst = 1'b0;
    #1;
    check("t5_rst_busy", bsy[0], 1'b0);
    check("t5_rst_hold", hold[0], 1'b0);
    check("t5_rst_inst_a2", ia2[0], 32'h0);
    check("t5_rst_inst_wd2", iwd2[0], 32'h0);
    check("t5_rst_rsp0", rv0[0], 1'b0);
    check("t5_rst_rdata", rdata[0], 32'h0);
    tick();
    tick();
    rst = 1'b1;
    s0[0] = 1; we0[0] = 0; a0[0] = 32'h30;
    s1[0] = 1; we1[0] = 0; a1[0] = 32'h40;
    v0[0] = 1; v1[0] = 1;
    #2;
    check("t5_rr_reset_ready0", rdy0[0], 1'b1);
    check("t5_rr_reset_ready1", rdy1[0], 1'b0);
    tick();
    v0[0] = 0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      if (c == 4) check("t5_req1_alone", rdy1[0], 1'b1);
      tick();
    end
    v1[0] = 0;
    n1 = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (rv1[0]) n1++;
      tick();
    end
    check("t5_req1_rsp_count", n1, 1);

    // Requester 0 pulses valid while busy, then drops it.
    ird[0] = 32'h01020304;
    s1[0] = 0; we1[0] = 0; a1[0] = 32'h50; v1[0] = 1;
    #2 check("t6_ready1_c0", rdy1[0], 1'b1);
    tick();
    v1[0] = 0;
    s0[0] = 1; we0[0] = 0; a0[0] = 32'h60; v0[0] = 1;
    #2 check("t6_ready0_busy", rdy0[0], 1'b0);
    tick();
    v0[0] = 0;
    n0 = 0; n1 = 0; got = 32'h0;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (rdy0[0] || rv0[0]) n0++;
      if (rv1[0]) begin n1++; got = rdata[0]; end
      tick();
    end
    check("t6_req0_never", n0, 0);
    check("t6_rsp1_count", n1, 1);
    check("t6_rdata", got, 32'h01020304);
    v0[0] = 1; v1[0] = 1;
    #2;
    check("t6_rr_unchanged_ready0", rdy0[0], 1'b1);
    check("t6_rr_unchanged_ready1", rdy1[0], 1'b0);
    tick();
    v0[0] = 0; v1[0] = 0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
